// File: rtl/p20_sprite_animator.sv
// Sprite-frame sequencer: divides clk by a runtime period and steps a frame index
// in loop, ping-pong, one-shot or hold mode, with a per-step strobe and sticky done.
module p20_sprite_animator #(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_W    = 2,
    parameter int unsigned DIV_W      = 25
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               halt,
    input  logic               restart,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   divider,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               done
);

    typedef enum logic [1:0] {
        ModeLoop     = 2'b00,
        ModePingPong = 2'b01,
        ModeOneShot  = 2'b10,
        ModeHold     = 2'b11
    } mode_e;

    localparam logic [FRAME_W-1:0] LastFrame = FRAME_W'(NUM_FRAMES - 1);
    localparam logic               DirUp     = 1'b0;
    localparam logic               DirDown   = 1'b1;

    logic [DIV_W-1:0]   ctr_q, ctr_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;

    mode_e              mode_s;
    logic [FRAME_W-1:0] frame_inc, frame_dec;
    logic               at_last, expired;
    logic [FRAME_W-1:0] step_frame;
    logic               step_dir, step_done;

    assign mode_s    = mode_e'(mode);
    assign frame_inc = frame_q + FRAME_W'(1);
    assign frame_dec = frame_q - FRAME_W'(1);
    assign at_last   = (frame_q == LastFrame);
    // >= rather than == so that lowering divider below ctr expires immediately.
    assign expired   = (ctr_q >= divider);

    // Frame/dir/done that a period expiry would produce in the current mode.
    always_comb begin
        step_frame = frame_q;
        step_dir   = DirUp;
        step_done  = 1'b0;
        unique case (mode_s)
            ModeLoop: begin
                step_frame = at_last ? '0 : frame_inc;
            end
            ModePingPong: begin
                step_dir = dir_q;
                if (NUM_FRAMES > 1) begin
                    if ((dir_q == DirUp && !at_last) || frame_q == '0) begin
                        step_frame = frame_inc;
                        step_dir   = (frame_inc == LastFrame) ? DirDown : DirUp;
                    end else begin
                        step_frame = frame_dec;
                        step_dir   = (frame_dec == '0) ? DirUp : DirDown;
                    end
                end
            end
            ModeOneShot: begin
                if (at_last) begin
                    step_done = 1'b1;
                end else begin
                    step_frame = frame_inc;
                    step_done  = (frame_inc == LastFrame);
                end
            end
            default: begin
                step_frame = frame_q;
            end
        endcase
    end

    always_comb begin
        ctr_d   = ctr_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        done_d  = done_q;
        tick_d  = 1'b0;
        if (restart) begin
            ctr_d   = '0;
            frame_d = '0;
            dir_d   = DirUp;
            done_d  = 1'b0;
        end else if (!halt) begin
            if (mode_s == ModeHold || done_q) begin
                ctr_d = '0;
            end else if (expired) begin
                ctr_d   = '0;
                tick_d  = 1'b1;
                frame_d = step_frame;
                dir_d   = step_dir;
                done_d  = step_done;
            end else begin
                ctr_d = ctr_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctr_q   <= '0;
            frame_q <= '0;
            dir_q   <= DirUp;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ctr_q   <= ctr_d;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign frame      = frame_q;
    assign frame_tick = tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_p20_sprite_animator.sv
// Self-checking bench for p20_sprite_animator (NUM_FRAMES=4): expected frames are
// queued when stimulus is applied and popped whenever the DUT emits frame_tick.
module tb_p20_sprite_animator;

    localparam int unsigned NF = 4;
    localparam int unsigned FW = 2;
    localparam int unsigned DW = 25;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          halt;
    logic          restart;
    logic [1:0]    mode;
    logic [DW-1:0] divider;
    logic [FW-1:0] frame;
    logic          frame_tick;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;
    logic [FW-1:0] exp_q[$];

    always #5 clk = ~clk;

    p20_sprite_animator #(
        .NUM_FRAMES(NF),
        .FRAME_W   (FW),
        .DIV_W     (DW)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .halt      (halt),
        .restart   (restart),
        .mode      (mode),
        .divider   (divider),
        .frame     (frame),
        .frame_tick(frame_tick),
        .done      (done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released 1 time unit after an edge; the next edge is cycle 1.
    task automatic do_reset(input logic [1:0] m, input int d);
        sys_rst = 1'b1;
        halt    = 1'b0;
        restart = 1'b0;
        mode    = m;
        divider = DW'(d);
        exp_q.delete();
        cyc();
        cyc();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2'b00, 3);
        vectors++;
        if ({frame, frame_tick, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: got frame=%0d tick=%0b done=%0b, want 0 0 0",
                     frame, frame_tick, done);
        end
        repeat (4) cyc();
        vectors++;
        if (frame !== 2'd1 || frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_async_reset: got frame=%0d tick=%0b, want 1 1", frame, frame_tick);
        end
        #2 sys_rst = 1'b1;
        #1;
        vectors++;
        if ({frame, frame_tick, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset: got frame=%0d tick=%0b done=%0b, want 0 0 0",
                     frame, frame_tick, done);
        end
    endtask

    task automatic test_loop();
        logic [FW-1:0] e;
        do_reset(2'b00, 3);
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int c = 1; c <= 20; c++) begin
            cyc();
            vectors++;
            if (frame_tick !== ((c % 4) == 0)) begin
                miscompares++;
                $display("FAIL loop_tick c=%0d: got %0b, want %0b", c, frame_tick, (c % 4) == 0);
            end
            if (frame_tick === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (frame !== e) begin
                    miscompares++;
                    $display("FAIL loop_frame c=%0d: got %0d, want %0d", c, frame, e);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL loop_leftover: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_pingpong();
        logic [FW-1:0] e;
        int ticks = 0;
        do_reset(2'b01, 3);
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        for (int c = 0; c < 40 && ticks < 7; c++) begin
            cyc();
            if (frame_tick === 1'b1) begin
                ticks++;
                e = exp_q.pop_front();
                vectors++;
                if (frame !== e) begin
                    miscompares++;
                    $display("FAIL pingpong_frame tick=%0d: got %0d, want %0d", ticks, frame, e);
                end
            end
        end
        vectors++;
        if (ticks != 7) begin
            miscompares++;
            $display("FAIL pingpong_timeout: got %0d ticks, want 7", ticks);
        end
    endtask

    task automatic test_oneshot();
        logic [FW-1:0] e;
        int ticks = 0;
        int extra = 0;
        do_reset(2'b10, 3);
        exp_q = '{2'd1, 2'd2, 2'd3};
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (frame_tick === 1'b1 && exp_q.size() > 0) begin
                ticks++;
                e = exp_q.pop_front();
                vectors++;
                if (frame !== e || done !== (ticks == 3)) begin
                    miscompares++;
                    $display("FAIL oneshot_step tick=%0d: got frame=%0d done=%0b, want %0d %0b",
                             ticks, frame, done, e, ticks == 3);
                end
            end
        end
        vectors++;
        if (ticks != 3) begin
            miscompares++;
            $display("FAIL oneshot_ticks: got %0d, want 3", ticks);
        end
        repeat (12) begin
            cyc();
            if (frame_tick === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0 || frame !== 2'd3 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_after_done: got extra=%0d frame=%0d done=%0b, want 0 3 1",
                     extra, frame, done);
        end
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        vectors++;
        if ({frame, frame_tick, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL oneshot_restart: got frame=%0d tick=%0b done=%0b, want 0 0 0",
                     frame, frame_tick, done);
        end
    endtask

    task automatic test_halt();
        logic [FW-1:0] e;
        do_reset(2'b00, 3);
        cyc();
        cyc();
        halt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            vectors++;
            if (frame_tick !== 1'b0 || frame !== 2'd0) begin
                miscompares++;
                $display("FAIL halt_frozen c=%0d: got frame=%0d tick=%0b, want 0 0",
                         c, frame, frame_tick);
            end
        end
        halt = 1'b0;
        exp_q.push_back(2'd1);
        cyc();
        vectors++;
        if (frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_release_early: got tick=%0b, want 0", frame_tick);
        end
        cyc();
        e = exp_q.pop_front();
        vectors++;
        if (frame_tick !== 1'b1 || frame !== e) begin
            miscompares++;
            $display("FAIL halt_release_tick: got tick=%0b frame=%0d, want 1 %0d",
                     frame_tick, frame, e);
        end
    endtask

    task automatic test_hold();
        logic [FW-1:0] e;
        do_reset(2'b00, 3);
        cyc();
        cyc();
        mode = 2'b11;
        repeat (5) begin
            cyc();
            vectors++;
            if (frame_tick !== 1'b0 || frame !== 2'd0) begin
                miscompares++;
                $display("FAIL hold_frozen: got frame=%0d tick=%0b, want 0 0", frame, frame_tick);
            end
        end
        mode = 2'b00;
        exp_q.push_back(2'd1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            vectors++;
            if (frame_tick !== (c == 4)) begin
                miscompares++;
                $display("FAIL hold_exit_tick c=%0d: got %0b, want %0b", c, frame_tick, c == 4);
            end
        end
        e = exp_q.pop_front();
        vectors++;
        if (frame !== e) begin
            miscompares++;
            $display("FAIL hold_exit_frame: got %0d, want %0d", frame, e);
        end
    endtask

    task automatic test_divider();
        logic [FW-1:0] e;
        do_reset(2'b00, 7);
        repeat (5) cyc();
        divider = DW'(1);
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        cyc();
        e = exp_q.pop_front();
        vectors++;
        if (frame_tick !== 1'b1 || frame !== e) begin
            miscompares++;
            $display("FAIL divider_lower: got tick=%0b frame=%0d, want 1 %0d", frame_tick, frame, e);
        end
        divider = '0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            e = exp_q.pop_front();
            vectors++;
            if (frame_tick !== 1'b1 || frame !== e) begin
                miscompares++;
                $display("FAIL divider_zero c=%0d: got tick=%0b frame=%0d, want 1 %0d",
                         c, frame_tick, frame, e);
            end
        end
        halt    = 1'b1;
        restart = 1'b1;
        cyc();
        vectors++;
        if ({frame, frame_tick, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL restart_over_halt: got frame=%0d tick=%0b done=%0b, want 0 0 0",
                     frame, frame_tick, done);
        end
        restart = 1'b0;
        cyc();
        vectors++;
        if (frame_tick !== 1'b0 || frame !== 2'd0) begin
            miscompares++;
            $display("FAIL halt_div0: got tick=%0b frame=%0d, want 0 0", frame_tick, frame);
        end
        halt = 1'b0;
        exp_q.push_back(2'd1);
        cyc();
        e = exp_q.pop_front();
        vectors++;
        if (frame_tick !== 1'b1 || frame !== e) begin
            miscompares++;
            $display("FAIL unhalt_div0: got tick=%0b frame=%0d, want 1 %0d", frame_tick, frame, e);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        halt    = 1'b0;
        restart = 1'b0;
        mode    = 2'b00;
        divider = DW'(3);
        test_reset();
        test_loop();
        test_pingpong();
        test_oneshot();
        test_halt();
        test_hold();
        test_divider();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
